// File: rtl/alu_sbc_unit_pkg.sv
// Shared definitions for the 6502 SBC unit: FSM encodings, BCD correction
// constants and the packed flag bundle.
package alu_sbc_unit_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LO   = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_ADJ  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [3:0] BCD_NIB_ADJ  = 4'h6;
    localparam logic [7:0] BCD_BYTE_ADJ = 8'h60;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } sbc_flags_t;

endpackage

// File: rtl/alu_sbc_unit_borrow_lookahead4.sv
// 4-bit borrow look-ahead subtractor slice: a - b - bin, with every
// internal borrow formed in parallel from propagate/generate terms.
module borrow_lookahead4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       bin_i,
    output logic [3:0] bout_o,
    output logic [3:0] diff_o
);

    logic [3:0] p;
    logic [3:0] g;

    // A borrow is generated when a=0,b=1 and propagated when a=0 or b=1.
    assign p = ~a_i | b_i;
    assign g = ~a_i & b_i;

    assign bout_o[0] = g[0] | (p[0] & bin_i);
    assign bout_o[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin_i);
    assign bout_o[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & bin_i);
    assign bout_o[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & bin_i);

    assign diff_o = a_i ^ b_i ^ {bout_o[2:0], bin_i};

endmodule

// File: rtl/alu_sbc_unit.sv
// Multi-cycle 6502 SBC: nibble-serial binary subtract through one shared
// borrow look-ahead slice, then optional NMOS decimal correction.
module alu_sbc_unit
    import alu_sbc_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    input  logic       D,
    output logic       busy,
    output logic       done,
    output logic [7:0] Result,
    output logic       N,
    output logic       V,
    output logic       Z,
    output logic       C
);

    logic [2:0]  state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        bin_q, bin_d;
    logic        dec_q, dec_d;
    logic [3:0]  dl_q, dl_d;
    logic        bl_q, bl_d;
    sbc_flags_t  bflg_q, bflg_d;
    sbc_flags_t  flg_q, flg_d;
    logic [7:0]  res_q, res_d;

    logic [3:0]  nib_a, nib_b, nib_diff, nib_bout;
    logic        nib_bin;
    logic [7:0]  r_bin;
    sbc_flags_t  hi_flags;

    logic signed [9:0] al_raw, al_fix, s_raw, s_fix;
    logic [7:0]        res_adj;
    logic [1:0]        adj_unused;

    // The single slice serves the low nibble in LO and the high nibble in HI.
    assign nib_a   = (state_q == ST_HI) ? a_q[7:4] : a_q[3:0];
    assign nib_b   = (state_q == ST_HI) ? b_q[7:4] : b_q[3:0];
    assign nib_bin = (state_q == ST_HI) ? bl_q     : bin_q;

    borrow_lookahead4 u_bla (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .bin_i  (nib_bin),
        .bout_o (nib_bout),
        .diff_o (nib_diff)
    );

    assign r_bin      = {nib_diff, dl_q};
    assign hi_flags.n = r_bin[7];
    assign hi_flags.z = (r_bin == 8'h00);
    assign hi_flags.v = (a_q[7] ^ b_q[7]) & (a_q[7] ^ r_bin[7]);
    assign hi_flags.c = ~nib_bout[3];

    // NMOS decimal correction, kept signed and 10 bits wide until the final slice.
    always_comb begin
        al_raw = $signed({6'b0, a_q[3:0]}) - $signed({6'b0, b_q[3:0]})
               - $signed({9'b0, bin_q});
        al_fix = al_raw[9] ? (((al_raw - $signed({6'b0, BCD_NIB_ADJ})) & 10'sh00F) - 10'sd16)
                           : al_raw;
        s_raw  = $signed({2'b0, a_q[7:4], 4'h0}) - $signed({2'b0, b_q[7:4], 4'h0}) + al_fix;
        s_fix  = s_raw[9] ? (s_raw - $signed({2'b0, BCD_BYTE_ADJ})) : s_raw;
    end

    assign res_adj    = s_fix[7:0];
    assign adj_unused = s_fix[9:8];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bin_d   = bin_q;
        dec_d   = dec_q;
        dl_d    = dl_q;
        bl_d    = bl_q;
        bflg_d  = bflg_q;
        flg_d   = flg_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    bin_d   = ~Cin;
                    dec_d   = D;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                dl_d    = nib_diff;
                bl_d    = nib_bout[3];
                state_d = ST_HI;
            end
            ST_HI: begin
                bflg_d = hi_flags;
                if (dec_q) begin
                    state_d = ST_ADJ;
                end else begin
                    res_d   = r_bin;
                    flg_d   = hi_flags;
                    state_d = ST_DONE;
                end
            end
            ST_ADJ: begin
                // Flags stay binary-derived; only the result is corrected.
                res_d   = res_adj;
                flg_d   = bflg_q;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            bin_q   <= 1'b0;
            dec_q   <= 1'b0;
            dl_q    <= 4'h0;
            bl_q    <= 1'b0;
            bflg_q  <= '0;
            flg_q   <= '0;
            res_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bin_q   <= bin_d;
            dec_q   <= dec_d;
            dl_q    <= dl_d;
            bl_q    <= bl_d;
            bflg_q  <= bflg_d;
            flg_q   <= flg_d;
            res_q   <= res_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign Result = res_q;
    assign N      = flg_q.n;
    assign V      = flg_q.v;
    assign Z      = flg_q.z;
    assign C      = flg_q.c;

endmodule
